// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the 1:4 stream demultiplexer
package demux_pkg;
  typedef logic [1:0] chan_sel_t;
  localparam int N_CHAN = 4;
endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry output register with valid flag and delivered-word counter
module demux_slot #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_cnt   <= '0;
    end else begin
      if (load) out_data <= load_data;
      out_valid <= load | (out_valid & ~out_ready);
      if (out_valid & out_ready) out_cnt <= out_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/demux_1_4_stream.sv
// demux_1_4_stream: routes a valid/ready word stream to one of four registered output channels
module demux_1_4_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  input  chan_sel_t                 in_sel,
  output logic [N_CHAN-1:0]         out_valid,
  input  logic [N_CHAN-1:0]         out_ready,
  output logic [N_CHAN*WIDTH-1:0]   out_data,
  output logic [N_CHAN*CNT_W-1:0]   out_cnt
);
  logic [N_CHAN-1:0] load;
  assign in_ready = ~out_valid[in_sel] | out_ready[in_sel];
  for (genvar i = 0; i < N_CHAN; i++) begin : g_slot
    assign load[i] = in_valid & in_ready & (in_sel == chan_sel_t'(i));
    demux_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk(clk),
      .rst_n(rst_n),
      .load(load[i]),
      .load_data(in_data),
      .out_valid(out_valid[i]),
      .out_ready(out_ready[i]),
      .out_data(out_data[i*WIDTH +: WIDTH]),
      .out_cnt(out_cnt[i*CNT_W +: CNT_W])
    );
  end
endmodule

// File: tb/tb_demux_1_4_stream.sv
// tb_demux_1_4_stream: directed scoreboard bench for the 1:4 stream demultiplexer
module tb_demux_1_4_stream;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [3:0]  in_data = '0;
  logic [1:0]  in_sel = '0;
  logic [3:0]  out_ready = '0;
  logic        in_ready, in_ready2;
  logic [3:0]  out_valid, out_valid2;
  logic [15:0] out_data, out_data2;
  logic [31:0] out_cnt;
  logic [7:0]  out_cnt2;
  int          checks = 0;
  int          errors = 0;
  logic [3:0]  q[4][$];
  logic [7:0]  exp_cnt[4];
  bit          en = 1'b0;

  demux_1_4_stream #(.WIDTH(4), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt)
  );

  demux_1_4_stream #(.WIDTH(4), .CNT_W(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .in_data(in_data), .in_sel(in_sel), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_cnt(out_cnt2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle(input logic r, input logic v, input logic [1:0] s,
                       input logic [3:0] d, input logic [3:0] ordy);
    @(negedge clk);
    rst_n = r; in_valid = v; in_sel = s; in_data = d; out_ready = ordy;
    #1;
    if (en) begin
      for (int c = 0; c < 4; c++) begin
        chk($sformatf("valid%0d", c), 32'(out_valid[c]), 32'(q[c].size() != 0));
        chk($sformatf("valid2_%0d", c), 32'(out_valid2[c]), 32'(q[c].size() != 0));
        chk($sformatf("cnt%0d", c), 32'(out_cnt[c*8 +: 8]), 32'(exp_cnt[c]));
        chk($sformatf("cnt2_%0d", c), 32'(out_cnt2[c*2 +: 2]), 32'(exp_cnt[c][1:0]));
        if (q[c].size() != 0)
          chk($sformatf("data%0d", c), 32'(out_data[c*4 +: 4]), 32'(q[c][0]));
      end
      if (v) chk("in_ready", 32'(in_ready), 32'(q[s].size() == 0 || ordy[s]));
    end
    if (!r) begin
      for (int c = 0; c < 4; c++) begin
        q[c].delete();
        exp_cnt[c] = '0;
      end
      en = 1'b1;
    end else begin
      for (int c = 0; c < 4; c++)
        if (q[c].size() != 0 && ordy[c]) begin
          void'(q[c].pop_front());
          exp_cnt[c]++;
        end
      if (v && q[s].size() == 0) q[s].push_back(d);
    end
  endtask

  initial begin
    cycle(0, 0, 0, 0, 4'h0);
    cycle(0, 1, 2, 4'h5, 4'h0);
    chk("rst_data", 32'(out_data), 32'h0);
    chk("rst_cnt", out_cnt, 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    // basic routing
    cycle(1, 1, 0, 4'ha, 4'hf);
    cycle(1, 1, 1, 4'hb, 4'hf);
    cycle(1, 1, 2, 4'hc, 4'hf);
    cycle(1, 1, 3, 4'hd, 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    chk("basic_cnt", out_cnt, 32'h01010101);
    // back-pressure isolation on channel 1
    cycle(1, 1, 1, 4'h7, 4'hd);
    cycle(1, 1, 1, 4'h3, 4'hd);
    chk("bp_in_ready", 32'(in_ready), 32'h0);
    cycle(1, 1, 2, 4'ha, 4'hd);
    chk("bp_hold", 32'(out_data[7:4]), 32'h7);
    cycle(1, 1, 1, 4'h3, 4'hd);
    cycle(1, 0, 0, 0, 4'hd);
    chk("bp_ch2_cnt", 32'(out_cnt[23:16]), 32'h2);
    chk("bp_still", 32'(out_data[7:4]), 32'h7);
    cycle(1, 1, 1, 4'h3, 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    // full throughput on channel 0
    cycle(0, 0, 0, 0, 4'hf);
    for (int i = 0; i < 8; i++) cycle(1, 1, 0, 4'(i + 1), 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    chk("tput_cnt", 32'(out_cnt[7:0]), 32'h8);
    // counter wrap on channel 3 of the narrow-counter instance
    cycle(0, 0, 0, 0, 4'hf);
    for (int i = 0; i < 5; i++) begin
      cycle(1, 1, 3, 4'(i + 9), 4'hf);
      cycle(1, 0, 0, 0, 4'hf);
    end
    cycle(1, 0, 0, 0, 4'hf);
    chk("wrap_cnt2", 32'(out_cnt2), 32'h40);
    // reset mid-operation
    for (int i = 0; i < 4; i++) cycle(1, 1, 2'(i), 4'(i + 4), 4'h0);
    cycle(1, 0, 0, 0, 4'h0);
    chk("full_valid", 32'(out_valid), 32'hf);
    cycle(0, 1, 1, 4'he, 4'h0);
    cycle(1, 0, 0, 0, 4'h0);
    chk("mid_rst_valid", 32'(out_valid), 32'h0);
    chk("mid_rst_cnt", out_cnt, 32'h0);
    chk("mid_rst_in_ready", 32'(in_ready), 32'h1);
    cycle(1, 1, 2, 4'h6, 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    chk("post_rst_route", 32'(out_data[11:8]), 32'h6);
    cycle(1, 0, 0, 0, 4'hf);
    // X on ignored inputs while a stalled word sits in channel 0
    cycle(1, 1, 0, 4'h9, 4'h0);
    for (int i = 0; i < 5; i++) cycle(1, 0, 2'bxx, 4'bxxxx, 4'h0);
    chk("x_valid", 32'(out_valid), 32'h1);
    chk("x_data", 32'(out_data[3:0]), 32'h9);
    cycle(1, 0, 0, 0, 4'hf);
    cycle(1, 0, 0, 0, 4'hf);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_1_4_stream.md
# demux_1_4_stream

Four-way stream demultiplexer: accepts WIDTH-bit words on one valid/ready input, each tagged with a 2-bit destination select, and delivers them to one of four valid/ready output channels. It is the distribution end for traffic that a 4:1 mux front-end merges, placed between a shared producer and four independent consumers. Each channel has its own one-entry output register, so a stalled consumer blocks only words addressed to it. Each channel also keeps a wrapping count of delivered words.

## Interface
- WIDTH, 4, data word width in bits.
- CNT_W, 8, width of each per-channel delivered-word counter.

- clk  input  1  clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  input word present.
- in_ready  output  1  block can accept the input word this cycle.
- in_data  input  WIDTH  input word.
- in_sel  input  2  destination channel 0..3.
- out_valid  output  4  bit i: channel i holds a word.
- out_ready  input  4  bit i: consumer i accepts this cycle.
- out_data  output  4*WIDTH  channel i word at bits [i*WIDTH +: WIDTH].
- out_cnt  output  4*CNT_W  channel i delivered-word count at bits [i*CNT_W +: CNT_W].

## Operation
- Input handshake: a word is taken when in_valid & in_ready.
- in_ready = ~out_valid[in_sel] | out_ready[in_sel]. This is combinational on in_sel and out_ready. It is independent of in_valid.
- On an accepted word, slot in_sel loads in_data and sets out_valid[in_sel]. Other slots are unaffected.
- Output handshake on channel i: the word leaves when out_valid[i] & out_ready[i]. out_valid[i] clears unless a new word loads into the same slot that cycle.
- Simultaneous drain and load on the same channel: the new word replaces the old one, out_valid stays 1, and throughput is 1 word/cycle per channel.
- out_data[i] holds stable while out_valid[i]=1 and not out_ready[i]. It is don't-care when out_valid[i]=0, but the RTL keeps the last value.
- When in_valid=0, in_sel and in_data are ignored. X on these inputs must not corrupt any slot.
- Counter i increments on each output handshake of channel i and wraps from 2^CNT_W-1 to 0. Counters are independent, so all four may increment in the same cycle.
- The block does not reorder words within a channel.
- The block does not guarantee ordering across channels.

## Timing
- Latency: a word accepted at edge N is visible on out_valid/out_data after edge N. The earliest output handshake is at edge N+1.
- Reset: while rst_n=0 at an edge, out_valid=4'b0, all out_cnt=0 and out_data=0.
  - in_ready then reads 1, because all slots are empty.
  - Words presented during reset are dropped.
- Reset mid-operation: held words are discarded and counters are cleared. Consumers must not sample out_valid during reset.
- No combinational path from in_valid to in_ready.
- The only combinational input-to-output path is out_ready/in_sel to in_ready.

## Structure
- Package demux_pkg holds:
  - typedef logic [1:0] chan_sel_t;
  - localparam N_CHAN = 4.
- Sub-module demux_slot, instantiated 4 times via generate, contains:
  - a one-entry data register with valid flag;
  - load/drain logic;
  - a CNT_W delivered-word counter;
  - ports clk, rst_n, load, load_data, out_valid, out_ready, out_data, out_cnt.
- The top level decodes in_sel into one-hot load enables gated by the input handshake, and computes in_ready.

## Test plan
- Basic routing:
  - After reset, send 'ha,'hb,'hc,'hd with sel 0,1,2,3, out_ready=4'hF.
  - Each out_valid[i] pulses one cycle after acceptance with data a,b,c,d.
  - Each out_cnt[i]=1 afterwards.
- Back-pressure isolation:
  - Hold out_ready[1]=0 and send 7 to ch1, then 3 to ch1.
  - in_ready goes to 0 for the second word, and out_data[1] stays 7.
  - Meanwhile send 10 to ch2, which is accepted and delivered.
- Full throughput:
  - Stream 8 words to ch0 back-to-back with out_ready[0]=1.
  - in_ready stays 1 and outputs appear in order, one per cycle.
  - out_cnt[0]=8.
- Counter wrap:
  - With CNT_W=2, deliver 5 words on ch3.
  - out_cnt[3] reads 1,2,3,0,1.
  - The other counters stay 0.
- Reset mid-operation:
  - Fill all four slots with out_ready=0, then pulse rst_n low for one edge.
  - out_valid=0, all counters are 0, and in_ready=1.
  - A subsequent word is routed normally.
- X handling:
  - With in_valid=0, drive in_sel/in_data to 'x for several cycles.
  - No out_valid changes and no counter changes occur.
